muldiv_sched: RTL and testbench

Multiply/divide unit with its own scheduler for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction and holds HI/LO. It runs a fixed-latency busy window and generates the D-stage stall request for any muldiv-class instruction that arrives while the unit is occupied.

---
 rtl/muldiv_sched.sv | 130 +++++++++++++
 tb/tb_muldiv_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// ============================================================================
//  muldiv_sched : E-stage multiply/divide unit with HI/LO, a fixed-latency busy
//                 window and the D-stage stall request.
//  Revision     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        sh_wr_q, sh_wr_d;

  logic        w_acc, w_is_mul, w_is_div, w_div_signed;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_div_safe, w_q, w_r, w_quot, w_rem;

  assign busy     = (state_q == S_RUN);
  assign w_acc    = start & ~flush & ~busy;
  assign w_is_mul = (op == 3'd1) || (op == 3'd2);
  assign w_is_div = (op == 3'd3) || (op == 3'd4);
  assign stall    = md_use_d & (busy | (start & ~flush & (w_is_mul | w_is_div)));

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign w_div_signed = (op == 3'd3);
  assign w_neg_a      = w_div_signed & src_a[31];
  assign w_neg_b      = w_div_signed & src_b[31];
  assign w_mag_a      = w_neg_a ? (~src_a + 32'd1) : src_a;
  assign w_mag_b      = w_neg_b ? (~src_b + 32'd1) : src_b;
  assign w_div_safe   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q          = w_mag_a / w_div_safe;
  assign w_r          = w_mag_a % w_div_safe;
  assign w_quot       = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
  assign w_rem        = w_neg_a ? (~w_r + 32'd1) : w_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    case (state_q)
      S_IDLE: begin
        if (w_acc) begin
          if (w_is_mul) begin
            {sh_hi_d, sh_lo_d} = (op == 3'd1) ? w_prod_s : w_prod_u;
            sh_wr_d = 1'b1;
            cnt_d   = 4'(MULT_LAT);
            state_d = S_RUN;
          end else if (w_is_div) begin
            sh_hi_d = w_rem;
            sh_lo_d = w_quot;
            sh_wr_d = (src_b != 32'd0);
            cnt_d   = 4'(DIV_LAT);
            state_d = S_RUN;
          end else if (op == 3'd5) begin
            hi_d = src_a;
          end else if (op == 3'd6) begin
            lo_d = src_a;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      sh_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// ============================================================================
//  tb_muldiv_sched : vector table, corner sequences and random ops against an
//                    arithmetic reference model of HI/LO.
//  Revision        : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_sched;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk, reset_n, start, flush, md_use_d;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .md_use_d(md_use_d),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MULT_LAT;
    if (o == 3'd3 || o == 3'd4) return DIV_LAT;
    return 0;
  endfunction

  // Reference model: plain integer arithmetic on the architectural HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nhi, output logic [31:0] nlo);
    longint sa, sb;
    longint unsigned p;
    int ia, ib;
    nhi = m_hi;
    nlo = m_lo;
    ia = a;
    ib = b;
    case (o)
      3'd1: begin sa = ia; sb = ib; p = longint'(sa * sb); {nhi, nlo} = p; end
      3'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); {nhi, nlo} = p; end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          nlo = 32'h8000_0000; nhi = 32'd0;
        end else begin
          nlo = ia / ib; nhi = ia % ib;
        end
      end
      3'd4: if (b != 0) begin nlo = a / b; nhi = a % b; end
      3'd5: nhi = a;
      3'd6: nlo = a;
      default: ;
    endcase
  endtask

  // Issues an op at the current negedge; checks stall, busy length, HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                        input logic md, input logic noise, input string nm);
    int n;
    bit longop;
    longop = (o >= 3'd1 && o <= 3'd4);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0; md_use_d = md;
    #1;
    chk({nm, ".stall_acc"}, {31'd0, stall}, {31'd0, md & longop});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk({nm, ".hold_hi"}, hi, m_hi);
      chk({nm, ".hold_lo"}, lo, m_lo);
      chk({nm, ".stall_busy"}, {31'd0, stall}, {31'd0, md});
      if (noise) begin
        start = 1'($urandom); op = 3'($urandom); flush = 1'($urandom);
        src_a = $urandom; src_b = $urandom;
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0; op = 3'd0;
      n++;
    end
    #1;
    chk({nm, ".lat"}, n, lat);
    chk({nm, ".hi"}, hi, ehi);
    chk({nm, ".lo"}, lo, elo);
    chk({nm, ".stall_idle"}, {31'd0, stall}, 32'd0);
    md_use_d = 1'b0;
    m_hi = ehi;
    m_lo = elo;
  endtask

  vec_t vecs[10];

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, ehi, elo;

    vecs[0] = '{3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000, 0};
    vecs[1] = '{3'd6, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[2] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_LAT};
    vecs[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_LAT};
    vecs[4] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[5] = '{3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[6] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
    vecs[7] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
    vecs[8] = '{3'd7, 32'hDEAD_BEEF, 32'd1, 32'h0000_0001, 32'h8000_0000, 0};
    vecs[9] = '{3'd4, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, DIV_LAT};
    vecs[8].ehi = 32'h0000_0001; // fixed below once preceding state is known
    vecs[8].ehi = vecs[7].ehi;
    vecs[8].elo = vecs[7].elo;

    start = 0; op = 0; src_a = 0; src_b = 0; flush = 0; md_use_d = 0;
    reset_n = 1'b0;
    m_hi = 0; m_lo = 0;
    #1;
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].lat,
             1'(i % 2), 1'b0, $sformatf("vec%0d", i));

    // Back-to-back mthi / mtlo on consecutive cycles.
    start = 1'b1; op = 3'd5; src_a = 32'h1234_5678;
    @(negedge clk);
    op = 3'd6; src_a = 32'h9ABC_DEF0;
    #1;
    chk("b2b.hi1", hi, 32'h1234_5678);
    chk("b2b.busy1", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    #1;
    chk("b2b.lo", lo, 32'h9ABC_DEF0);
    chk("b2b.busy2", {31'd0, busy}, 32'd0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    @(negedge clk);

    // Flushed mult and flushed mthi do nothing.
    start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9; flush = 1'b1; md_use_d = 1'b1;
    #1;
    chk("flush.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    op = 3'd5;
    #1;
    chk("flush.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0; md_use_d = 1'b0; op = 3'd0;
    #1;
    chk("flush.hi", hi, m_hi);
    chk("flush.lo", lo, m_lo);
    @(negedge clk);

    // Random ops with noise (ignored starts, flushes) during RUN.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      model(ro, ra, rb, ehi, elo);
      run_op(ro, ra, rb, ehi, elo, lat_of(ro), 1'($urandom), 1'b1, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a multiply.
    start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstrun.hi", hi, 32'd0);
    chk("rstrun.lo", lo, 32'd0);
    chk("rstrun.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    chk("rstrun.idle", {31'd0, busy}, 32'd0);
    run_op(3'd6, 32'd7, 32'd0, 32'd0, 32'd7, 0, 1'b0, 1'b0, "rstrun.mtlo");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
